// File: rtl/shift_unit_iter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_unit_iter_pkg;

    typedef enum logic [1:0] {
        OP_SHR = 2'b00,
        OP_SAR = 2'b01,
        OP_SHL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of at most STEP bits, used once per SHIFT cycle.
module shift_step
    import shift_unit_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] s,
    input  op_e              op,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] sign_mask;

    // Bits vacated by a right shift; only consulted for SAR.
    assign sign_mask = ~({WIDTH{1'b1}} >> s);

    always_comb begin
        result = data;
        case (op)
            OP_SHR:  result = data >> s;
            OP_SAR:  result = (data >> s) | (fill ? sign_mask : '0);
            OP_SHL:  result = data << s;
            // s is always below WIDTH for ROR, so the wrap shift never exceeds WIDTH.
            OP_ROR:  result = (data >> s) | (data << (CNT_W'(WIDTH) - s));
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: SHR/SAR/SHL/ROR, at most STEP bits per cycle, valid/ready on both sides.
module shift_unit_iter
    import shift_unit_iter_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned STEP  = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_n,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    op_e              op_q, op_d;
    logic             fill_q, fill_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_data_d;
    logic             in_ready_d, out_valid_d;

    logic [CNT_W-1:0] n_eff_c;
    logic [CNT_W-1:0] s_c;
    logic [WIDTH-1:0] step_c;

    // Effective amount: rotates wrap modulo WIDTH, plain shifts saturate at WIDTH.
    always_comb begin
        n_eff_c = '0;
        if (op_e'(in_op) == OP_ROR) begin
            n_eff_c = CNT_W'(in_n % CNT_W'(WIDTH));
        end else if (in_n > CNT_W'(WIDTH)) begin
            n_eff_c = CNT_W'(WIDTH);
        end else begin
            n_eff_c = in_n;
        end
    end

    assign s_c = (rem_q < CNT_W'(STEP)) ? rem_q : CNT_W'(STEP);

    shift_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .data   (data_q),
        .s      (s_c),
        .op     (op_q),
        .fill   (fill_q),
        .result (step_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        op_d       = op_q;
        fill_d     = fill_q;
        rem_d      = rem_q;
        out_data_d = out_data;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    op_d    = op_e'(in_op);
                    fill_d  = in_data[WIDTH-1];
                    rem_d   = n_eff_c;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A zero amount still passes through here once with s = 0.
                data_d = step_c;
                rem_d  = rem_q - s_c;
                if (rem_q == s_c) begin
                    out_data_d = step_c;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            op_q      <= OP_SHR;
            fill_q    <= 1'b0;
            rem_q     <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            op_q      <= op_d;
            fill_q    <= fill_d;
            rem_q     <= rem_d;
            out_data  <= out_data_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed and random checks of shift_unit_iter against an arithmetic reference model.
module tb_shift_unit_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 8;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_n;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    shift_unit_iter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_n      (in_n),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic int eff_amount(input int n, input int op);
        if (op == 3) return n % 32;
        return (n > 32) ? 32 : n;
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] d, input int n, input int op);
        logic [63:0] wide;
        int ne;
        ne = eff_amount(n, op);
        case (op)
            0:       wide = {32'h0, d} >> ne;
            1:       wide = {{32{d[31]}}, d} >> ne;
            2:       wide = {32'h0, d} << ne;
            default: wide = {d, d} >> ne;
        endcase
        return wide[31:0];
    endfunction

    function automatic int ref_latency(input int n, input int op);
        int ne;
        ne = eff_amount(n, op);
        return (ne == 0) ? 1 : (ne + 7) / 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one request, wait for its result, optionally stall the consumer, then accept.
    task automatic run_op(input logic [31:0] d, input int n, input int op,
                          input int idle, input int stall, input bit poke);
        logic [31:0] expv;
        int          k;
        int          lat;
        expv = ref_result(d, n, op);
        k    = ref_latency(n, op);
        repeat (idle) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_n     = CNT_W'(n);
        in_op    = 2'(op);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_n      = CNT_W'($urandom);
        in_op     = 2'($urandom);
        out_ready = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(k));
        check("result", out_data, expv);
        check("in_ready_done", 32'(in_ready), 32'd0);
        if (stall > 0) begin
            out_ready = 1'b0;
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 32'hDEADBEEF;
                in_n     = CNT_W'(1);
                in_op    = 2'd0;
            end
            repeat (stall) begin
                @(posedge clk);
                #1;
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, expv);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("data_held", out_data, expv);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_n      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SHR boundary amounts on an all-ones operand.
        run_op(32'hFFFFFFFF, 0, 0, 0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 1, 0, 0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 4, 0, 0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 15, 0, 0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 31, 0, 0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32, 0, 0, 0, 1'b0);
        check("shr15_const", ref_result(32'hFFFFFFFF, 15, 0), 32'h0001FFFF);

        // Reset held mid-SHIFT aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_n     = CNT_W'(32);
        in_op    = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hA5A5A5A5, 12, 0, 1, 0, 1'b0);

        // SAR, SHL and ROR directed cases.
        run_op(32'h80000000, 4, 1, 0, 0, 1'b0);
        run_op(32'h80000000, 40, 1, 0, 0, 1'b0);
        run_op(32'h00000001, 31, 2, 0, 0, 1'b0);
        run_op(32'h00000001, 4, 3, 0, 0, 1'b0);
        run_op(32'h00000001, 36, 3, 0, 0, 1'b0);
        run_op(32'h00000001, 32, 3, 0, 0, 1'b0);

        // Backpressure for 5 cycles with a competing request that must be ignored.
        run_op(32'h0F0F1234, 20, 2, 0, 5, 1'b1);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            int idle;
            int stall;
            idle  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op($urandom, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                   idle, stall, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
